// File: rtl/bram_tdp_rr_arbiter.sv
// Purpose: round-robin share of one true-dual-port no-change BRAM among NUM_REQ requesters (two grants per cycle, A then B).
// Latency: grant is combinational; read data returns to the issuing requester RD_LATENCY+1 cycles after the grant.
// Backpressure: req_ready is the grant; ungranted requests simply wait, and no response path can stall.
module bram_tdp_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                         clka,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_REQ*RAM_WIDTH-1:0] rsp_rdata,
  output logic                         ram_ena,
  output logic                         ram_enb,
  output logic                         ram_wea,
  output logic                         ram_web,
  output logic [AW-1:0]                ram_addra,
  output logic [AW-1:0]                ram_addrb,
  output logic [RAM_WIDTH-1:0]         ram_dina,
  output logic [RAM_WIDTH-1:0]         ram_dinb,
  output logic                         ram_regcea,
  output logic                         ram_regceb,
  output logic                         ram_rsta,
  output logic                         ram_rstb,
  input  logic [RAM_WIDTH-1:0]         ram_douta,
  input  logic [RAM_WIDTH-1:0]         ram_doutb
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One entry of the per-port read-return pipeline: is it a read, and whose.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]       rr_ptr;
  logic [AW-1:0]        addr_arr  [NUM_REQ];
  logic [RAM_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [RAM_WIDTH-1:0] rdata_q   [NUM_REQ];
  logic                 a_found, b_found, b_conflict;
  logic                 grant_a, grant_b;
  logic [IDW-1:0]       a_idx, b_idx;
  int                   scan_idx;
  tag_t                 pipe_a [RD_LATENCY];
  tag_t                 pipe_b [RD_LATENCY];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]                        = req_addr[i*AW +: AW];
    assign wdata_arr[i]                       = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
    assign rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = rdata_q[i];
  end

  assign ram_regcea = 1'b1;
  assign ram_regceb = 1'b1;
  assign ram_rsta   = ~rst_n;
  assign ram_rstb   = ~rst_n;

  // Scan from rr_ptr: first valid requester is the A candidate, the next one the B candidate.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = IDW'(scan_idx);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = IDW'(scan_idx);
        end
      end
    end
  end

  // Same-address pairs involving a write are serialised so the BRAM never sees a port collision.
  assign b_conflict = a_found && b_found && (addr_arr[a_idx] == addr_arr[b_idx]) &&
                      (req_we[a_idx] || req_we[b_idx]);
  assign grant_a    = rst_n && a_found;
  assign grant_b    = rst_n && b_found && !b_conflict;

  // Drive the grants and both BRAM ports; an idle port is fully zeroed.
  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[a_idx] = 1'b1;
    if (grant_b) req_ready[b_idx] = 1'b1;
    ram_ena   = grant_a;
    ram_wea   = grant_a && req_we[a_idx];
    ram_addra = grant_a ? addr_arr[a_idx]  : '0;
    ram_dina  = grant_a ? wdata_arr[a_idx] : '0;
    ram_enb   = grant_b;
    ram_web   = grant_b && req_we[b_idx];
    ram_addrb = grant_b ? addr_arr[b_idx]  : '0;
    ram_dinb  = grant_b ? wdata_arr[b_idx] : '0;
  end

  // Advance the pointer past the last requester actually granted.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_b) begin
      rr_ptr <= (b_idx == IDW'(NUM_REQ - 1)) ? '0 : b_idx + 1'b1;
    end else if (grant_a) begin
      rr_ptr <= (a_idx == IDW'(NUM_REQ - 1)) ? '0 : a_idx + 1'b1;
    end
  end

  // Read tags travel alongside the BRAM read pipeline so each result knows its owner.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_a[s] <= '0;
        pipe_b[s] <= '0;
      end
    end else begin
      pipe_a[0] <= '{vld: grant_a && !req_we[a_idx], id: a_idx};
      pipe_b[0] <= '{vld: grant_b && !req_we[b_idx], id: b_idx};
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_a[s] <= pipe_a[s-1];
        pipe_b[s] <= pipe_b[s-1];
      end
    end
  end

  // Register the returning data into the owner's slot as a one-cycle pulse.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
    end else begin
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pipe_a[RD_LATENCY-1].vld && pipe_a[RD_LATENCY-1].id == IDW'(i)) begin
          rsp_valid[i] <= 1'b1;
          rdata_q[i]   <= ram_douta;
        end else if (pipe_b[RD_LATENCY-1].vld && pipe_b[RD_LATENCY-1].id == IDW'(i)) begin
          rsp_valid[i] <= 1'b1;
          rdata_q[i]   <= ram_doutb;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_tdp_rr_arbiter.sv
// Purpose: directed check of the BRAM arbiter with a HIGH_PERFORMANCE instance and a LOW_LATENCY instance.
// Latency: BRAM models here add 2 (u_dut) and 1 (u_dut_ll) read cycles.
// Backpressure: requesters hold req_valid until the step that expects the grant.
module tb_bram_tdp_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 10;

  logic           clka;
  logic           rst_n;
  int             n_cmp;
  int             n_err;

  // HIGH_PERFORMANCE instance signals
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata, rsp_rdata;
  logic            ram_ena, ram_enb, ram_wea, ram_web;
  logic [AW-1:0]   ram_addra, ram_addrb;
  logic [W-1:0]    ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic            ram_regcea, ram_regceb, ram_rsta, ram_rstb;

  // LOW_LATENCY instance signals
  logic [N-1:0]    ll_req_valid, ll_req_we, ll_req_ready, ll_rsp_valid;
  logic [N*AW-1:0] ll_req_addr;
  logic [N*W-1:0]  ll_req_wdata, ll_rsp_rdata;
  logic            ll_ena, ll_enb, ll_wea, ll_web;
  logic [AW-1:0]   ll_addra, ll_addrb;
  logic [W-1:0]    ll_dina, ll_dinb, ll_douta, ll_doutb;
  logic            ll_regcea, ll_regceb, ll_rsta, ll_rstb;

  logic [W-1:0] mem    [1024];
  logic [W-1:0] ll_mem [1024];
  logic [W-1:0] a_r1, a_r2, b_r1, b_r2;

  bram_tdp_rr_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(1024), .RD_LATENCY(2)) u_dut (
    .clka(clka), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_regcea(ram_regcea), .ram_regceb(ram_regceb), .ram_rsta(ram_rsta), .ram_rstb(ram_rstb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  bram_tdp_rr_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(1024), .RD_LATENCY(1)) u_dut_ll (
    .clka(clka), .rst_n(rst_n),
    .req_valid(ll_req_valid), .req_we(ll_req_we), .req_addr(ll_req_addr), .req_wdata(ll_req_wdata),
    .req_ready(ll_req_ready), .rsp_valid(ll_rsp_valid), .rsp_rdata(ll_rsp_rdata),
    .ram_ena(ll_ena), .ram_enb(ll_enb), .ram_wea(ll_wea), .ram_web(ll_web),
    .ram_addra(ll_addra), .ram_addrb(ll_addrb), .ram_dina(ll_dina), .ram_dinb(ll_dinb),
    .ram_regcea(ll_regcea), .ram_regceb(ll_regceb), .ram_rsta(ll_rsta), .ram_rstb(ll_rstb),
    .ram_douta(ll_douta), .ram_doutb(ll_doutb)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // No-change TDP BRAM, two read stages (output register always enabled).
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      else         a_r1 <= mem[ram_addra];
    end
    if (ram_enb) begin
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      else         b_r1 <= mem[ram_addrb];
    end
    a_r2 <= a_r1;
    b_r2 <= b_r1;
  end
  assign ram_douta = a_r2;
  assign ram_doutb = b_r2;

  // No-change TDP BRAM, single read stage.
  logic [W-1:0] lla_r1, llb_r1;
  always @(posedge clka) begin
    if (ll_ena) begin
      if (ll_wea) ll_mem[ll_addra] <= ll_dina;
      else        lla_r1 <= ll_mem[ll_addra];
    end
    if (ll_enb) begin
      if (ll_web) ll_mem[ll_addrb] <= ll_dinb;
      else        llb_r1 <= ll_mem[ll_addrb];
    end
  end
  assign ll_douta = lla_r1;
  assign ll_doutb = llb_r1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input logic [W-1:0] wd);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_wdata[i*W +: W]   = wd;
  endtask

  // Step to one time unit after the next rising edge, then let inputs settle before checks.
  task automatic next_cyc();
    @(posedge clka);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = '0;
      ll_mem[i] = '0;
    end
    mem[5]    = 16'hBEEF;
    mem[9]    = 16'h00AA;
    for (int i = 0; i < 4; i++) mem[16+i] = 16'hA000 + 16'(i);
    ll_mem[5] = 16'hBEEF;
    a_r1 = '0; a_r2 = '0; b_r1 = '0; b_r2 = '0; lla_r1 = '0; llb_r1 = '0;
    ll_req_valid = '0; ll_req_we = '0; ll_req_addr = '0; ll_req_wdata = '0;
    req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset with all requesters asserting: nothing may be granted.
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    next_cyc();
    next_cyc();
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_ena_enb", {ram_ena, ram_enb}, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    chk("rst_ram_rst_regce", {ram_rsta, ram_rstb, ram_regcea, ram_regceb}, 4'b1111);
    rst_n = 1'b1;
    req_valid = '0;
    next_cyc();
    chk("idle_ram_rst", {ram_rsta, ram_rstb}, 2'b00);
    chk("idle_port_zero", {ram_ena, ram_wea, ram_addra, ram_dina}, 28'h0);

    // Single read: req0 reads addr 5, response exactly 3 cycles later on slot 0.
    set_req(0, 1'b0, 5, 16'h0);
    #1;
    chk("s1_ready", req_ready, 4'b0001);
    chk("s1_porta", {ram_ena, ram_wea, ram_addra}, {1'b1, 1'b0, 10'd5});
    chk("s1_portb_idle", {ram_enb, ram_web, ram_addrb, ram_dinb}, 28'h0);
    next_cyc();
    req_valid = '0;
    chk("s1_rsp_c1", rsp_valid, 4'h0);
    next_cyc();
    chk("s1_rsp_c2", rsp_valid, 4'h0);
    next_cyc();
    chk("s1_rsp_c3", rsp_valid, 4'b0001);
    chk("s1_data", rsp_rdata[15:0], 16'hBEEF);
    next_cyc();
    chk("s1_rsp_c4", rsp_valid, 4'h0);

    // rr_ptr is 1: a lone write from req3 lands on port A and moves rr_ptr back to 0.
    set_req(3, 1'b1, 20, 16'h5555);
    #1;
    chk("wr_ready", req_ready, 4'b1000);
    chk("wr_porta", {ram_ena, ram_wea, ram_addra, ram_dina}, {1'b1, 1'b1, 10'd20, 16'h5555});
    next_cyc();
    req_valid = '0;
    next_cyc();
    next_cyc();
    chk("wr_no_rsp", rsp_valid, 4'h0);

    // All four read: pairs {0,1}, {2,3}, {0,1}.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16 + i, 16'h0);
    #1;
    chk("s2_g0_ready", req_ready, 4'b0011);
    chk("s2_g0_addr", {ram_addra, ram_addrb}, {10'd16, 10'd17});
    next_cyc();
    chk("s2_g1_ready", req_ready, 4'b1100);
    chk("s2_g1_addr", {ram_addra, ram_addrb}, {10'd18, 10'd19});
    next_cyc();
    chk("s2_g2_ready", req_ready, 4'b0011);
    next_cyc();
    req_valid = '0;
    chk("s2_rsp0", rsp_valid, 4'b0011);
    chk("s2_data0", rsp_rdata[31:0], {16'hA001, 16'hA000});
    next_cyc();
    chk("s2_rsp1", rsp_valid, 4'b1100);
    chk("s2_data1", rsp_rdata[63:32], {16'hA003, 16'hA002});
    next_cyc();
    chk("s2_rsp2", rsp_valid, 4'b0011);
    chk("s2_data2", rsp_rdata[31:0], {16'hA001, 16'hA000});
    next_cyc();
    chk("s2_rsp3", rsp_valid, 4'h0);

    // rr_ptr is 2: req2 and req3 both read addr 9 in the same cycle.
    set_req(2, 1'b0, 9, 16'h0);
    set_req(3, 1'b0, 9, 16'h0);
    #1;
    chk("s4_ready", req_ready, 4'b1100);
    chk("s4_ports", {ram_ena, ram_enb, ram_addra, ram_addrb}, {2'b11, 10'd9, 10'd9});
    next_cyc();
    req_valid = '0;
    next_cyc();
    next_cyc();
    chk("s4_rsp", rsp_valid, 4'b1100);
    chk("s4_data", rsp_rdata[63:32], {16'h00AA, 16'h00AA});

    // rr_ptr is 0: req0 writes addr 7, req1 reads addr 7 -> serialised.
    set_req(0, 1'b1, 7, 16'h1234);
    set_req(1, 1'b0, 7, 16'h0);
    #1;
    chk("s3_ready_w", req_ready, 4'b0001);
    chk("s3_porta", {ram_ena, ram_wea, ram_addra, ram_dina}, {1'b1, 1'b1, 10'd7, 16'h1234});
    chk("s3_portb_idle", ram_enb, 1'b0);
    next_cyc();
    req_valid[0] = 1'b0;
    #1;
    chk("s3_ready_r", req_ready, 4'b0010);
    next_cyc();
    req_valid = '0;
    next_cyc();
    next_cyc();
    chk("s3_rsp", rsp_valid, 4'b0010);
    chk("s3_data", rsp_rdata[31:16], 16'h1234);

    // rr_ptr is 2: req0 read granted, then a one-cycle reset discards it.
    set_req(0, 1'b0, 5, 16'h0);
    #1;
    chk("s5_ready", req_ready, 4'b0001);
    next_cyc();
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("s5_ready_rst", req_ready, 4'h0);
    chk("s5_en_rst", {ram_ena, ram_enb}, 2'b00);
    next_cyc();
    rst_n = 1'b1;
    req_valid = '0;
    chk("s5_rsp_a", rsp_valid, 4'h0);
    next_cyc();
    chk("s5_rsp_b", rsp_valid, 4'h0);
    next_cyc();
    chk("s5_rsp_c", rsp_valid, 4'h0);
    // rr_ptr must be 0 again: req0 takes port A, req3 port B.
    set_req(0, 1'b0, 5, 16'h0);
    set_req(3, 1'b0, 9, 16'h0);
    #1;
    chk("s5_ptr_ready", req_ready, 4'b1001);
    chk("s5_ptr_addr", {ram_addra, ram_addrb}, {10'd5, 10'd9});
    next_cyc();
    req_valid = '0;
    next_cyc();
    next_cyc();
    chk("s5_post_rsp", rsp_valid, 4'b1001);
    chk("s5_post_data", {rsp_rdata[63:48], rsp_rdata[15:0]}, {16'h00AA, 16'hBEEF});

    // LOW_LATENCY instance: read addr 5, response 2 cycles after the grant.
    ll_req_valid[0] = 1'b1;
    ll_req_we[0]    = 1'b0;
    ll_req_addr[9:0] = 10'd5;
    #1;
    chk("s6_ready", ll_req_ready, 4'b0001);
    next_cyc();
    ll_req_valid = '0;
    chk("s6_rsp_c1", ll_rsp_valid, 4'h0);
    next_cyc();
    chk("s6_rsp_c2", ll_rsp_valid, 4'b0001);
    chk("s6_data", ll_rsp_rdata[15:0], 16'hBEEF);
    next_cyc();
    chk("s6_rsp_c3", ll_rsp_valid, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
